mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, consecutive data grants allowed while a fetch waits (used only with MEM_ARB_STARVE_GUARD_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 ifReq  input  1  fetch-stage read request; held until ifDone seen.
REQ-005 ifAddr  input  16  fetch address; stable while ifReq high.
REQ-006 dmReq  input  1  memory-stage access request; held until dmDone seen.
REQ-007 dmWr  input  1  1=write, 0=read; stable while dmReq high.
REQ-008 dmAddr  input  16  data address; stable while dmReq high.
REQ-009 dmWrData  input  16  write data; stable while dmReq high.
REQ-010 memDataOut  input  16  read data from the shared single-port memory; valid with memDone.
REQ-011 memDone  input  1  memory completion strobe; one cycle.
REQ-012 memEn  output  1  memory start strobe; one cycle per transaction.
REQ-013 memWr  output  1  memory write select.
REQ-014 memAddr  output  16  memory address.
REQ-015 memDataIn  output  16  memory write data.
REQ-016 ifRdData  output  16  registered fetch read data.
REQ-017 ifDone  output  1  fetch completion pulse.
REQ-018 dmRdData  output  16  registered data read data.
REQ-019 dmDone  output  1  data completion pulse.
REQ-020 stallIf  output  1  fetch-stage stall.
REQ-021 stallMem  output  1  memory-stage stall.

Function
REQ-022 FSM states: IDLE, DATA, INST, RESP; at most one transaction outstanding.
REQ-023 IDLE: dmReq high -> DATA; else ifReq high -> INST; else stay IDLE (data has priority, except as REQ-036).
REQ-024 On grant, latch wr/addr/wrdata of the winner into registers; memAddr/memWr/memDataIn drive these registers and hold stable through DATA/INST; fetch grants drive memWr=0.
REQ-025 memEn = 1 only in the first cycle of DATA or INST; 0 in every other cycle.
REQ-026 DATA/INST: stay until memDone; memDone in the same cycle as memEn (zero-wait) is accepted.
REQ-027 On memDone in DATA: capture memDataOut into dmRdData (reads only; writes leave dmRdData unchanged) and go to RESP.
REQ-028 On memDone in INST: capture memDataOut into ifRdData and go to RESP.
REQ-029 RESP: one cycle; dmDone or ifDone (whichever was served) = 1; requests ignored; next state IDLE.
REQ-030 Latency: grant cycle + memory wait + 1; minimum 3 cycles from IDLE request sample to done pulse.
REQ-031 stallMem = dmReq & ~dmDone; stallIf = ifReq & ~ifDone; combinational.
REQ-032 Requester deasserting its req mid-transaction: transaction still completes and its done still pulses.
REQ-033 memDone outside DATA/INST is ignored.

Reset
REQ-034 rst_n low: state IDLE, memEn/memWr/ifDone/dmDone = 0, memAddr/memDataIn/ifRdData/dmRdData = 16'h0000, starve counter = 0; in-flight transaction abandoned, no done pulse issued.
REQ-035 After rst_n rises, the first grant occurs no earlier than the first rising edge with rst_n high.

Configuration
REQ-036 MEM_ARB_STARVE_GUARD_EN defined: a counter counts consecutive DATA grants made while ifReq is high; it clears on any INST grant or in any IDLE cycle with ifReq low; when the count equals STARVE_LIMIT and both requests are high in IDLE, INST is granted.
REQ-037 MEM_ARB_STARVE_GUARD_EN undefined: no counter logic; data always wins per REQ-023.

Verification
REQ-038 Fetch alone: ifReq, ifAddr=16'h0040, memDone 2 cycles after memEn with memDataOut=16'hBEEF -> memEn one cycle, memWr=0, ifRdData=16'hBEEF, ifDone one cycle, stallIf low in the RESP cycle.
REQ-039 Simultaneous ifReq and dmReq (write, dmAddr=16'h0100, dmWrData=16'h1234) -> data served first (memWr=1, memAddr=16'h0100, memDataIn=16'h1234), dmRdData unchanged, fetch served next.
REQ-040 Zero-wait memory (memDone with memEn) -> done pulse exactly 2 cycles after grant; no repeated grant in RESP.
REQ-041 rst_n low mid-DATA -> all outputs reset immediately, no dmDone, IDLE after release.
REQ-042 MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=3, dmReq and ifReq continuously high -> grant order D,D,D,I,D,D,D,I; without the macro -> only D grants.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the data port and the shared single-port memory port
// of mem_port_arbiter; the arbiter uses the slave modport.
interface mem_port_arbiter_if;
  logic        ifReq;
  logic [15:0] ifAddr;
  logic        dmReq;
  logic        dmWr;
  logic [15:0] dmAddr;
  logic [15:0] dmWrData;
  logic [15:0] memDataOut;
  logic        memDone;
  logic        memEn;
  logic        memWr;
  logic [15:0] memAddr;
  logic [15:0] memDataIn;
  logic [15:0] ifRdData;
  logic        ifDone;
  logic [15:0] dmRdData;
  logic        dmDone;
  logic        stallIf;
  logic        stallMem;

  modport slave (
    input  ifReq, ifAddr, dmReq, dmWr, dmAddr, dmWrData, memDataOut, memDone,
    output memEn, memWr, memAddr, memDataIn, ifRdData, ifDone, dmRdData, dmDone,
           stallIf, stallMem
  );

  modport master (
    output ifReq, ifAddr, dmReq, dmWr, dmAddr, dmWrData, memDataOut, memDone,
    input  memEn, memWr, memAddr, memDataIn, ifRdData, ifDone, dmRdData, dmDone,
           stallIf, stallMem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-stage requests onto one single-port memory, one transaction
// at a time. Optional fetch anti-starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DATA, INST, RESP} state_t;

  state_t      state;
  state_t      nextState;
  logic        grantData;
  logic        grantInst;
  logic        starveHit;
  logic        firstCycle;
  logic        servedData;
  logic        memWrReg;
  logic [15:0] memAddrReg;
  logic [15:0] memDataInReg;
  logic [15:0] ifRdDataReg;
  logic [15:0] dmRdDataReg;

  // Data wins in IDLE unless the starvation guard says the fetch has waited long enough.
  always_comb begin
    nextState = state;
    grantData = 1'b0;
    grantInst = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dmReq && !starveHit) begin
          grantData = 1'b1;
          nextState = DATA;
        end else if (bus.ifReq) begin
          grantInst = 1'b1;
          nextState = INST;
        end
      end
      DATA, INST: begin
        if (bus.memDone) nextState = RESP;
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // firstCycle is set only by a grant, so memEn covers exactly the first DATA/INST cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      firstCycle   <= 1'b0;
      servedData   <= 1'b0;
      memWrReg     <= 1'b0;
      memAddrReg   <= 16'h0000;
      memDataInReg <= 16'h0000;
    end else begin
      state      <= nextState;
      firstCycle <= grantData | grantInst;
      if (grantData) begin
        servedData   <= 1'b1;
        memWrReg     <= bus.dmWr;
        memAddrReg   <= bus.dmAddr;
        memDataInReg <= bus.dmWrData;
      end else if (grantInst) begin
        servedData <= 1'b0;
        memWrReg   <= 1'b0;
        memAddrReg <= bus.ifAddr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifRdDataReg <= 16'h0000;
      dmRdDataReg <= 16'h0000;
    end else if (bus.memDone) begin
      if (state == DATA && !memWrReg) dmRdDataReg <= bus.memDataOut;
      if (state == INST) ifRdDataReg <= bus.memDataOut;
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starveCount;

  assign starveHit = bus.ifReq && (starveCount == CW'(STARVE_LIMIT));

  // Counts back-to-back data grants taken while a fetch was pending; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCount <= '0;
    end else if (state == IDLE) begin
      if (grantInst || !bus.ifReq) begin
        starveCount <= '0;
      end else if (grantData && (starveCount != CW'(STARVE_LIMIT))) begin
        starveCount <= starveCount + 1'b1;
      end
    end
  end
`else
  assign starveHit = 1'b0;
`endif

  assign bus.memEn     = firstCycle;
  assign bus.memWr     = memWrReg;
  assign bus.memAddr   = memAddrReg;
  assign bus.memDataIn = memDataInReg;
  assign bus.ifRdData  = ifRdDataReg;
  assign bus.dmRdData  = dmRdDataReg;
  assign bus.dmDone    = (state == RESP) && servedData;
  assign bus.ifDone    = (state == RESP) && !servedData;
  assign bus.stallMem  = bus.dmReq & ~bus.dmDone;
  assign bus.stallIf   = bus.ifReq & ~bus.ifDone;

endmodule
